decoder_proj_formal_dut: RTL and testbench
==========================================

// Module: decoder_proj_formal_dut
// PURPOSE
//  Registered combinational-decoder block for the decoder project. Samples a 7-bit io_in
//  bus and produces a 3-to-8 one-hot decode, a hex 7-segment decode, parity and a change
//  flag, all registered with one cycle of latency. It is the unit wrapped by the formal
//  cover/assert harness and driven directly by pad inputs.
// PARAMETERS
//  SEL_W   3  width of select field io_in[6:4]; one-hot output is 2**SEL_W bits
//  NIB_W   4  width of data nibble io_in[3:0]; fixed at 4 for the hex table
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst_n      in   1   reset; asynchronous, active-low
//  io_in      in   7   [6:4] select, [3:0] hex nibble
//  onehot_o   out  8   registered one-hot decode of io_in[6:4]
//  seg_o      out  7   registered 7-seg pattern {g,f,e,d,c,b,a}, active-high
//  parity_o   out  1   registered XOR-reduce of io_in
//  change_o   out  1   1-cycle pulse: io_in differs from previous sample
//  valid_o    out  1   high from first clk edge after reset release onward
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync release on clk): onehot_o=0, seg_o=0, parity_o=0,
//    change_o=0, valid_o=0, internal prev_q=0. Reset mid-operation clears all at once.
//  - Each rising clk with rst_n=1: onehot_o <= 1<<io_in[6:4]; seg_o <= HEX(io_in[3:0]);
//    parity_o <= ^io_in; valid_o <= 1; prev_q <= io_in.
//  - change_o <= valid_o && (io_in != prev_q); first sample after reset never flags change.
//  - Latency: output reflects io_in sampled at previous edge (1 cycle), no handshake.
//  - HEX table 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//  - Invariant: once valid_o=1, onehot_o has exactly one bit set; seg_o never 0.
//  - io_in X/Z not handled; inputs assumed synchronous to clk.
// CONFIGURATION
//  - DECODER_FORMAL_EN defined: embed assertions (onehot_o one-hot when valid_o, seg_o
//    equals HEX(prev_q[3:0]), parity_o == ^prev_q, all outputs 0 in reset) and cover points
//    for every select value and every nibble value; assumes rst_n low on first cycle.
//  - Not defined: no formal constructs; synthesizable logic identical.
// STRUCTURE
//  - Package decoder_proj_pkg: SEL_W/NIB_W constants, seg7_t typedef (7 bits), HEX table
//    constant and function hex_to_seg(nibble).
//  - One sub-module: seg7_decode (combinational nibble -> seg7_t via package function).
//  - Top holds all flops, one-hot shift, parity, change detect and formal block.
// TESTING
//  - rst_n=0, io_in=7'b1111111 -> all outputs 0 while in reset, no change_o.
//  - Release reset, io_in=7'b1010001 -> next cycle onehot_o=8'h20, seg_o=7'h06,
//    parity_o=1, valid_o=1, change_o=0.
//  - Hold io_in 3 cycles -> change_o stays 0; switch to 7'b0001010 -> onehot_o=8'h01,
//    seg_o=7'h77, parity_o=0, change_o=1 for exactly one cycle.
//  - Sweep nibble 0..F with select 7 -> seg_o follows HEX table, onehot_o=8'h80.
//  - Assert rst_n low asynchronously between edges -> outputs 0 immediately, valid_o=0;
//    re-release -> first sample change_o=0.
//  - With DECODER_FORMAL_EN: prove all assertions and hit all 8+16 cover points.

Source files
------------

// File: rtl/decoder_proj_pkg.sv
// Shared constants, 7-segment type and hex lookup for the decoder project.
package decoder_proj_pkg;

    localparam int SEL_W    = 3;
    localparam int NIB_W    = 4;
    localparam int IO_W     = SEL_W + NIB_W;
    localparam int ONEHOT_W = 1 << SEL_W;

    // Segment order is {g,f,e,d,c,b,a}, a lit segment is 1.
    typedef logic [6:0] seg7_t;

    localparam seg7_t HEX_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg7_t hex_to_seg(input logic [NIB_W-1:0] nibble);
        return HEX_TABLE[nibble];
    endfunction

endpackage

// File: rtl/decoder_proj_formal_dut_seg7_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
module seg7_decode
    import decoder_proj_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output seg7_t            seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/decoder_proj_formal_dut.sv
// Registered one-hot / 7-seg / parity / change decoder for the pad io_in bus.
// Define DECODER_FORMAL_EN to embed the formal assertions and cover points.
module decoder_proj_formal_dut
    import decoder_proj_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IO_W-1:0]     io_in,
    output logic [ONEHOT_W-1:0] onehot_o,
    output logic [6:0]          seg_o,
    output logic                parity_o,
    output logic                change_o,
    output logic                valid_o
);

    logic [IO_W-1:0]     prev_q;
    logic [ONEHOT_W-1:0] onehot_d;
    seg7_t               seg_d;
    logic                parity_d;
    logic                change_d;

    seg7_decode u_seg7_decode (
        .nibble (io_in[NIB_W-1:0]),
        .seg    (seg_d)
    );

    // valid_o gates change detection so the first sample after reset never flags.
    always_comb begin
        onehot_d = ONEHOT_W'(1) << io_in[IO_W-1:NIB_W];
        parity_d = ^io_in;
        change_d = valid_o && (io_in != prev_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_o <= '0;
            seg_o    <= '0;
            parity_o <= 1'b0;
            change_o <= 1'b0;
            valid_o  <= 1'b0;
            prev_q   <= '0;
        end else begin
            onehot_o <= onehot_d;
            seg_o    <= seg_d;
            parity_o <= parity_d;
            change_o <= change_d;
            valid_o  <= 1'b1;
            prev_q   <= io_in;
        end
    end

`ifdef DECODER_FORMAL_EN
    logic firstCycle = 1'b1;

    // Marks the very first clock of the formal trace so reset can be assumed there.
    always_ff @(posedge clk) begin
        firstCycle <= 1'b0;
    end

    assume property (@(posedge clk) firstCycle |-> !rst_n);

    assert property (@(posedge clk) disable iff (!rst_n)
        valid_o |-> $onehot(onehot_o));

    assert property (@(posedge clk) disable iff (!rst_n)
        valid_o |-> (seg_o == hex_to_seg(prev_q[NIB_W-1:0])));

    assert property (@(posedge clk) disable iff (!rst_n)
        valid_o |-> (parity_o == ^prev_q));

    assert property (@(posedge clk) disable iff (!rst_n)
        valid_o |-> (seg_o != '0));

    // Reset clears asynchronously, so the zero check is level-sensitive.
    always_comb begin
        if (!rst_n) begin
            assert (onehot_o == '0 && seg_o == '0 && !parity_o &&
                    !change_o && !valid_o && prev_q == '0);
        end
    end

    for (genvar s = 0; s < ONEHOT_W; s++) begin : g_cover_sel
        cover property (@(posedge clk) valid_o && onehot_o[s]);
    end

    for (genvar n = 0; n < 16; n++) begin : g_cover_nib
        cover property (@(posedge clk) valid_o && prev_q[NIB_W-1:0] == NIB_W'(n));
    end
`else
`endif

endmodule

// File: tb/tb_decoder_proj_formal_dut.sv
// Directed self-checking bench for decoder_proj_formal_dut.
module tb_decoder_proj_formal_dut;

    logic       clk;
    logic       rst_n;
    logic [6:0] io_in;
    logic [7:0] onehot_o;
    logic [6:0] seg_o;
    logic       parity_o;
    logic       change_o;
    logic       valid_o;

    int total;
    int bad;

    logic [6:0] hex_exp [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    decoder_proj_formal_dut dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_in    (io_in),
        .onehot_o (onehot_o),
        .seg_o    (seg_o),
        .parity_o (parity_o),
        .change_o (change_o),
        .valid_o  (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive a new sample between edges, then wait until just after it is captured.
    task automatic applyStimulus(input logic [6:0] val);
        @(negedge clk);
        io_in = val;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] exp_onehot,
                               input logic [6:0] exp_seg, input logic exp_parity,
                               input logic exp_change, input logic exp_valid);
        total++;
        assert (onehot_o === exp_onehot) else begin
            bad++;
            $error("[TB] FAIL %s onehot_o got=%h want=%h", tag, onehot_o, exp_onehot);
        end
        total++;
        assert (seg_o === exp_seg) else begin
            bad++;
            $error("[TB] FAIL %s seg_o got=%h want=%h", tag, seg_o, exp_seg);
        end
        total++;
        assert (parity_o === exp_parity) else begin
            bad++;
            $error("[TB] FAIL %s parity_o got=%b want=%b", tag, parity_o, exp_parity);
        end
        total++;
        assert (change_o === exp_change) else begin
            bad++;
            $error("[TB] FAIL %s change_o got=%b want=%b", tag, change_o, exp_change);
        end
        total++;
        assert (valid_o === exp_valid) else begin
            bad++;
            $error("[TB] FAIL %s valid_o got=%b want=%b", tag, valid_o, exp_valid);
        end
    endtask

    initial begin
        logic [6:0] v;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        io_in = 7'b1111111;

        $display("[TB] reset phase");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("in_reset", 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        io_in = 7'b1010001;
        @(posedge clk);
        #1;
        checkOutput("in_reset_2", 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_sample", 8'h20, 7'h06, 1'b1, 1'b0, 1'b1);

        $display("[TB] hold phase");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(7'b1010001);
            checkOutput("hold", 8'h20, 7'h06, 1'b1, 1'b0, 1'b1);
        end

        applyStimulus(7'b0001010);
        checkOutput("switch", 8'h01, 7'h77, 1'b0, 1'b1, 1'b1);
        applyStimulus(7'b0001010);
        checkOutput("switch_hold", 8'h01, 7'h77, 1'b0, 1'b0, 1'b1);

        $display("[TB] nibble sweep with select 7");
        for (int n = 0; n < 16; n++) begin
            v = {3'b111, 4'(n)};
            applyStimulus(v);
            checkOutput($sformatf("sweep_%0d", n), 8'h80, hex_exp[n], ^v, 1'b1, 1'b1);
        end

        $display("[TB] asynchronous reset mid-cycle");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);
        io_in = 7'h33;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rerelease", 8'h08, 7'h4F, 1'b0, 1'b0, 1'b1);

        applyStimulus(7'h33);
        checkOutput("rerelease_hold", 8'h08, 7'h4F, 1'b0, 1'b0, 1'b1);
        applyStimulus(7'h00);
        checkOutput("zero_input", 8'h01, 7'h3F, 1'b0, 1'b1, 1'b1);
        applyStimulus(7'h64);
        checkOutput("sel6_nib4", 8'h40, 7'h66, 1'b1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
